// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial (3-bit slice) add/subtract controller.
package serial_add_ctrl_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle for serial_add_ctrl; the ovf signal exists only when
// SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

// File: rtl/serial_add_ctrl_add_slice3.sv
// Combinational 3-bit carry-lookahead adder slice used once per RUN cycle.
module add_slice3
  import serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carries expanded from generate/propagate so no ripple path exists
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & cin_i);

  assign sum_o  = p ^ c[SLICE_W-1:0];
  assign cout_o = c[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle A+B / A-B over WIDTH/3 slices of one shared 3-bit CLA adder.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// RUN   | one 3-bit slice added per cycle, index 0..N-1
// DONE  | out_valid high, result held until out_ready
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

  add_slice3 u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (carry_q),
    .sum_o  (sl_sum),
    .cout_o (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        // Subtract folds into add: invert B here, carry-in of 1 supplies the +1
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;

`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf = (state_q == DONE) &&
                   (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (sum_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=12): directed vectors, stall, hold and reset cases.
module tb_serial_add_ctrl;
  localparam int WIDTH = 12;
  localparam int N     = WIDTH / 3;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             exp_q[$];
  int               acc_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  int               acc_cnt  = 0;
  logic             ov_prev  = 1'b0;
  logic [WIDTH-1:0] sum_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: latency, hold and scoreboard comparison, all sampled on the falling edge
  always @(negedge clk) begin
    int   c0;
    exp_t e;
    if (!rst_n) begin
      acc_q.delete();
      ov_prev = 1'b0;
    end else begin
      cyc++;
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back(cyc);
        acc_cnt++;
      end
      if (bus.out_valid && !ov_prev) begin
        if (acc_q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        else begin
          c0 = acc_q.pop_front();
          check("latency", 32'(cyc - c0), 32'(N + 1));
        end
      end
      if (bus.out_valid && ov_prev) check("sum_hold", 32'(bus.sum), 32'(sum_prev));
      if (bus.out_valid) check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'(bus.out_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sum", 32'(bus.sum), 32'(e.sum));
          check("cout", 32'(bus.cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        end
      end
      ov_prev  = bus.out_valid;
      sum_prev = bus.sum;
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = eo;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    logic took;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    do begin
      took = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 50);
    if (!took) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    bus.a        = 12'($urandom);
    bus.b        = 12'($urandom);
    bus.sub      = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("idle_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    push_exp(es, ec, eo);
    issue(a, b, s);
    wait_idle();
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1 check_reset_values();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic vectors: a, b, sub -> sum, cout, ovf
    send(12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    send(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    send(12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 1'b0);
    send(12'h007, 12'h005, 1'b1, 12'h002, 1'b1, 1'b0);
    send(12'hABC, 12'hDEF, 1'b0, 12'h8AB, 1'b1, 1'b0);
    send(12'h000, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0);

    // Consumer stalls for 10 cycles in DONE
    bus.out_ready = 1'b0;
    push_exp(12'h7FF, 1'b1, 1'b1);
    issue(12'h800, 12'h001, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_reach_done", 32'(bus.out_valid), 32'd1);
    repeat (10) begin
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_sum", 32'(bus.sum), 32'h7FF);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_release", 32'(bus.in_ready), 32'd1);

    // in_valid held with scrambled operands during RUN
    acc0 = acc_cnt;
    push_exp(12'h579, 1'b0, 1'b0);
    issue(12'h123, 12'h456, 1'b0);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      bus.a   = 12'($urandom);
      bus.b   = 12'($urandom);
      bus.sub = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1 check("single_accept", 32'(acc_cnt - acc0), 32'd1);

    // Reset in the second RUN cycle discards the operation
    issue(12'h555, 12'h222, 1'b0);
    @(posedge clk); #1;
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_values();
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("no_valid_after_reset", 32'(bus.out_valid), 32'd0);
    end
    send(12'h555, 12'h222, 1'b0, 12'h777, 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 12, operand/result width in bits; SHALL be a multiple of 3 and >= 6.
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port in_valid  input  1  request valid.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port sub  input  1  1 = A-B, 0 = A+B.
REQ-009 Port out_valid  output  1  result valid.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 Port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-013 Port busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; N = WIDTH/3 slice steps.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready.
REQ-016 On accept: latch a, b xor {WIDTH{sub}}, sub; carry register <= sub; slice index <= 0; go to RUN.
REQ-017 Each RUN cycle SHALL add 3-bit slice k of latched A and effective B with carry register through one 3-bit carry-lookahead slice, write 3 sum bits at [3k+2:3k], update carry, increment k.
REQ-018 After slice N-1 SHALL go to DONE; out_valid asserts exactly N+1 cycles after the accept edge.
REQ-019 In DONE out_valid=1 and sum/cout stable until out_valid && out_ready; then go to IDLE; in_ready returns the following cycle (no same-cycle re-accept).
REQ-020 in_valid, a, b, sub SHALL be ignored outside IDLE; operand changes during RUN SHALL not affect the result.
REQ-021 out_ready ignored outside DONE; out_ready held high causes no extra handshake.
REQ-022 Slice index SHALL not wrap; out-of-range index unreachable.
REQ-023 Full-scale carry/borrow wraps modulo 2^WIDTH, reported only on cout.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry and index 0 (ovf=0 when compiled in).
REQ-025 Reset mid-RUN or mid-DONE SHALL discard the operation; no out_valid follows reset release.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN defined: add port ovf  output  1, signed overflow = (A msb == effB msb) && (sum msb != A msb), valid with out_valid, held in DONE.
REQ-027 Macro undefined: no ovf port, no overflow logic; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold FSM state enum (IDLE/RUN/DONE) and constant SLICE_W = 3.
REQ-029 One sub-module add_slice3: combinational 3-bit carry-lookahead adder (a, b, cin -> sum, cout), instantiated once.

Verification (WIDTH=12)
REQ-030 a=0x7FF, b=0x001, sub=0 -> sum=0x800, cout=0, ovf=1, out_valid 5 cycles after accept.
REQ-031 a=0xFFF, b=0x001, sub=0 -> sum=0x000, cout=1, ovf=0.
REQ-032 a=0x005, b=0x007, sub=1 -> sum=0xFFE, cout=0; a=0x007, b=0x005, sub=1 -> sum=0x002, cout=1.
REQ-033 out_ready low 10 cycles in DONE -> out_valid, sum held, in_ready=0 throughout; release -> IDLE next cycle.
REQ-034 in_valid held with changing a/b during RUN -> single result from originally latched operands, no second accept until IDLE.
REQ-035 rst_n pulsed low in RUN cycle 2 -> outputs reset values at once, no out_valid after release; next request computes correctly.
